// File: rtl/ddr_port_arbiter.sv
// Two-port round-robin arbiter in front of a DDR controller; one transaction in flight.
// Optional watchdog on the response phase is enabled with `define ARB_TIMEOUT_EN.
module ddr_port_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [63:0] m0_addr,
  input  logic [63:0] m0_wdata,
  input  logic [7:0]  m0_wmask,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [63:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [63:0] m1_addr,
  input  logic [63:0] m1_wdata,
  input  logic [7:0]  m1_wmask,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [63:0] m1_rdata,
  output logic        mem_valid,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata,
  output logic [1:0]  debug_arb_state,
  output logic [31:0] debug_visit_times,
  output logic        debug_timeout
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

  arb_state_e  state_r;
  logic        prio_r;    // port that wins the next tie
  logic        owner_r;
  logic        lat_we_r;
  logic [63:0] lat_addr_r;
  logic [63:0] lat_wdata_r;
  logic [7:0]  lat_wmask_r;
  logic [31:0] visit_r;

  logic        grant_s;
  logic        winner_s;
  logic        resp_s;
  logic        tmo_s;
  logic        done_s;
  logic        sel_we_s;
  logic [63:0] sel_addr_s;
  logic [63:0] sel_wdata_s;
  logic [7:0]  sel_wmask_s;

  // Round-robin winner selection, only while idle and out of reset
  always_comb begin
    grant_s  = 1'b0;
    winner_s = 1'b0;
    if (!rst && (state_r == ST_IDLE)) begin
      if (m0_req && m1_req) begin
        grant_s  = 1'b1;
        winner_s = prio_r;
      end else if (m0_req) begin
        grant_s  = 1'b1;
        winner_s = 1'b0;
      end else if (m1_req) begin
        grant_s  = 1'b1;
        winner_s = 1'b1;
      end else begin
        grant_s  = 1'b0;
        winner_s = 1'b0;
      end
    end else begin
      grant_s  = 1'b0;
      winner_s = 1'b0;
    end
  end

  // Request fields of the selected port
  always_comb begin
    if (winner_s) begin
      sel_we_s    = m1_we;
      sel_addr_s  = m1_addr;
      sel_wdata_s = m1_wdata;
      sel_wmask_s = m1_wmask;
    end else begin
      sel_we_s    = m0_we;
      sel_addr_s  = m0_addr;
      sel_wdata_s = m0_wdata;
      sel_wmask_s = m0_wmask;
    end
  end

  assign resp_s = !rst && (state_r == ST_WAIT) && mem_rvalid;

`ifdef ARB_TIMEOUT_EN
  logic [9:0] wait_cnt_r;
  logic       timeout_r;

  assign tmo_s         = !rst && (state_r == ST_WAIT) && !mem_rvalid && (wait_cnt_r == 10'd1023);
  assign debug_timeout = timeout_r;

  // Watchdog: held at zero until WAIT is entered, then counts WAIT cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_r <= 10'd0;
      timeout_r  <= 1'b0;
    end else begin
      if (state_r == ST_WAIT) begin
        wait_cnt_r <= wait_cnt_r + 10'd1;
      end else begin
        wait_cnt_r <= 10'd0;
      end
      timeout_r <= timeout_r | tmo_s;
    end
  end
`else
  assign tmo_s         = 1'b0;
  assign debug_timeout = 1'b0;
`endif

  assign done_s = resp_s | tmo_s;

  // Arbitration FSM and request latches
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      prio_r      <= 1'b0;
      owner_r     <= 1'b0;
      lat_we_r    <= 1'b0;
      lat_addr_r  <= 64'd0;
      lat_wdata_r <= 64'd0;
      lat_wmask_r <= 8'd0;
      visit_r     <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (grant_s) begin
            owner_r     <= winner_s;
            prio_r      <= ~winner_s;
            lat_we_r    <= sel_we_s;
            lat_addr_r  <= sel_addr_s;
            lat_wdata_r <= sel_wdata_s;
            lat_wmask_r <= sel_wmask_s;
            state_r     <= ST_ISSUE;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          if (mem_ready) begin
            state_r <= ST_WAIT;
          end else begin
            state_r <= ST_ISSUE;
          end
        end
        ST_WAIT: begin
          if (resp_s) begin
            visit_r <= visit_r + 32'd1;
            state_r <= ST_IDLE;
          end else if (tmo_s) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign m0_gnt    = grant_s & ~winner_s;
  assign m1_gnt    = grant_s & winner_s;
  assign m0_rvalid = done_s & ~owner_r;
  assign m1_rvalid = done_s & owner_r;
  // Timeout completions return zero data
  assign m0_rdata  = (resp_s && !owner_r) ? mem_rdata : 64'd0;
  assign m1_rdata  = (resp_s && owner_r) ? mem_rdata : 64'd0;

  assign mem_valid         = (state_r == ST_ISSUE);
  assign mem_we            = lat_we_r;
  assign mem_addr          = lat_addr_r;
  assign mem_wdata         = lat_wdata_r;
  assign mem_wmask         = lat_wmask_r;
  assign debug_arb_state   = state_r;
  assign debug_visit_times = visit_r;

endmodule

// File: doc/ddr_port_arbiter.md
DDR_PORT_ARBITER -- requirements
Module: ddr_port_arbiter

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with these ports:
- clk  in  1  core clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
REQ-002 Requester port k, for k in {0 = instruction fetch, 1 = data}, SHALL be:
- mk_req  in  1  request; held until grant
- mk_we  in  1  write request
- mk_addr  in  64  byte address
- mk_wdata  in  64  write data
- mk_wmask  in  8  byte-write mask
- mk_gnt  out  1  one-cycle grant pulse; request captured
- mk_rvalid  out  1  one-cycle completion pulse, reads and writes
- mk_rdata  out  64  read data; valid only with mk_rvalid
REQ-003 The memory-side port SHALL be:
- mem_valid  out  1  request to memory controller
- mem_we  out  1  latched write enable
- mem_addr  out  64  latched address
- mem_wdata  out  64  latched write data
- mem_wmask  out  8  latched write mask
- mem_ready  in  1  controller accepts request
- mem_rvalid  in  1  controller completion
- mem_rdata  in  64  controller read data
REQ-004 The debug port SHALL be:
- debug_arb_state  out  2  FSM state: 0 IDLE, 1 ISSUE, 2 WAIT
- debug_visit_times  out  32  count of completed transactions
- debug_timeout  out  1  sticky watchdog flag

Function
REQ-005 The FSM SHALL have three states: IDLE, ISSUE, WAIT. Only one transaction SHALL be outstanding at any time.
REQ-006 In IDLE with at least one mk_req high, the block SHALL select a winner and behave as follows in the same cycle:
- assert the winner's mk_gnt combinationally
- latch the winner's we, addr, wdata and wmask
- record the winner's index
- move to ISSUE
REQ-007 In IDLE with no request, no mk_gnt SHALL be asserted and the state SHALL stay IDLE.
REQ-008 Selection SHALL be round-robin:
- single requester wins
- on a tie, the port not granted last wins
- after reset, port 0 wins the first tie
REQ-009 In ISSUE, mem_valid SHALL be 1 with the latched fields. When mem_ready=1, the state SHALL move to WAIT and mem_valid SHALL be 0 from the next cycle.
REQ-010 In WAIT, mem_valid SHALL be 0. When mem_rvalid=1, the block SHALL:
- pulse the recorded port's mk_rvalid in that same cycle, with mk_rdata equal to mem_rdata (combinational pass-through)
- increment debug_visit_times (wraps 2^32-1 to 0)
- move to IDLE
REQ-011 mem_rvalid in IDLE or ISSUE SHALL be ignored.
REQ-012 A new grant SHALL occur no earlier than the cycle after completion. Minimum turnaround is 3 cycles per transaction: grant, issue, completion.
REQ-013 Requests arriving while not in IDLE SHALL NOT be granted. They SHALL be arbitrated on the next IDLE cycle.
REQ-014 mk_rdata for the non-recorded port SHALL be 0. mk_gnt and mk_rvalid SHALL never both be high for the same port in one cycle.

Reset
REQ-015 On rst=1 at a clock edge, the block SHALL:
- go to IDLE
- set the tie priority to port 0
- zero all latched fields and debug_visit_times
- clear debug_timeout
- drive all outputs 0 from that edge
REQ-016 Reset mid-transaction SHALL abandon the transaction; no mk_rvalid SHALL be produced for it.

Configuration
REQ-017 With ARB_TIMEOUT_EN defined, a 10-bit counter SHALL run in WAIT. On reaching 1023 without mem_rvalid, the block SHALL:
- pulse the recorded port's mk_rvalid with mk_rdata=0
- set debug_timeout (cleared only by reset)
- not increment debug_visit_times
- return to IDLE
The counter SHALL clear on entry to WAIT.
REQ-018 Without ARB_TIMEOUT_EN, WAIT SHALL wait indefinitely and debug_timeout SHALL be tied to 0.

Verification
REQ-019 Single read: m0_req=1, addr=0x80000000; mem_ready one cycle after ISSUE; mem_rvalid 2 cycles later with rdata=0x1122334455667788 -> m0_gnt at cycle 0, mem_valid cycles 1-2, m0_rvalid with that data, debug_visit_times=1.
REQ-020 Tie: m0_req and m1_req held high after reset, memory responds immediately -> grants in order m0, m1, m0, m1; no overlap of outstanding transactions.
REQ-021 Write: m1_we=1, wmask=0x0F, wdata=0xDEADBEEF -> mem_we=1, mem_wmask=0x0F, mem_wdata=0xDEADBEEF while mem_valid; m1_rvalid pulses on mem_rvalid.
REQ-022 Backpressure: mem_ready held 0 for 5 cycles -> mem_valid stays 1 with stable fields for all 5; no second grant.
REQ-023 Reset in WAIT: rst asserted for 1 cycle, then mem_rvalid pulsed -> no mk_rvalid; debug_arb_state=0; debug_visit_times=0.
REQ-024 With ARB_TIMEOUT_EN: mem_rvalid never returned -> m0_rvalid with rdata=0 exactly 1023 cycles after WAIT entry; debug_timeout=1; debug_visit_times unchanged.
